// File: rtl/iir_biquad_coef_ctrl.sv
// iir_biquad_coef_ctrl: stages biquad coefficients and moves them to the core only on safe sample boundaries, as a jump or a per-sample ramp
module iir_biquad_coef_ctrl #(
    parameter int N_BITS_P = 32,
    parameter int Q_BITS_P = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_wr_en,
    input  logic [2:0]          cfg_wr_addr,
    input  logic [N_BITS_P-1:0] cfg_wr_data,
    input  logic                cfg_commit,
    input  logic                cfg_ramp_en,
    input  logic [N_BITS_P-1:0] cfg_ramp_step,
    input  logic                x0_valid,
    input  logic                x0_ready,
    input  logic                y0_valid,
    output logic [N_BITS_P-1:0] cr_zero_b0,
    output logic [N_BITS_P-1:0] cr_zero_b1,
    output logic [N_BITS_P-1:0] cr_zero_b2,
    output logic [N_BITS_P-1:0] cr_pole_a1,
    output logic [N_BITS_P-1:0] cr_pole_a2,
    output logic                sts_busy,
    output logic                sts_done
);
    typedef enum logic [1:0] {IDLE, PENDING, RAMPING} state_t;
    localparam logic [N_BITS_P-1:0] unity = N_BITS_P'(1) << Q_BITS_P;
    state_t              state, state_nxt;
    logic [N_BITS_P-1:0] stg [5];
    logic [N_BITS_P-1:0] tgt [5];
    logic [N_BITS_P-1:0] act [5];
    logic [N_BITS_P-1:0] stg_byp [5];
    logic [N_BITS_P-1:0] ramp_val [5];
    logic [4:0]          at_tgt;
    logic [N_BITS_P-1:0] step;
    logic                ramp_mode;
    logic                safe, sample;
    logic                load_tgt, load_ramp, done_nxt;
    assign safe   = y0_valid || (x0_ready && !x0_valid);
    assign sample = y0_valid;
    for (genvar i = 0; i < 5; i++) begin : g_coef
        logic [N_BITS_P:0] diff;
        logic [N_BITS_P:0] mag;
        assign stg_byp[i]  = (cfg_wr_en && cfg_wr_addr == 3'(i)) ? cfg_wr_data : stg[i];
        assign diff        = {tgt[i][N_BITS_P-1], tgt[i]} - {act[i][N_BITS_P-1], act[i]};
        assign mag         = diff[N_BITS_P] ? -diff : diff;
        assign ramp_val[i] = (mag <= {1'b0, step}) ? tgt[i] :
                             diff[N_BITS_P] ? act[i] - step : act[i] + step;
        assign at_tgt[i]   = ramp_val[i] == tgt[i];
    end
    assign cr_zero_b0 = act[0];
    assign cr_zero_b1 = act[1];
    assign cr_zero_b2 = act[2];
    assign cr_pole_a1 = act[3];
    assign cr_pole_a2 = act[4];
    assign sts_busy   = state != IDLE;
    // state register and registered done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sts_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            sts_done <= done_nxt;
        end
    end
    // next state: a commit always restarts from PENDING; transfers only on safe/sample edges
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        load_tgt  = 1'b0;
        load_ramp = 1'b0;
        if (cfg_commit) begin
            state_nxt = PENDING;
        end else if (state == PENDING && safe) begin
            load_tgt  = !ramp_mode || step == '0;
            load_ramp = ramp_mode && step != '0;
            done_nxt  = load_tgt || &at_tgt;
            state_nxt = done_nxt ? IDLE : RAMPING;
        end else if (state == RAMPING && sample) begin
            load_ramp = 1'b1;
            done_nxt  = &at_tgt;
            state_nxt = done_nxt ? IDLE : RAMPING;
        end
    end
    // coefficient banks: staging with write bypass into target, active moved by jump or ramp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_mode <= 1'b0;
            step      <= '0;
            for (int k = 0; k < 5; k++) begin
                stg[k] <= k == 0 ? unity : '0;
                tgt[k] <= k == 0 ? unity : '0;
                act[k] <= k == 0 ? unity : '0;
            end
        end else begin
            if (cfg_commit) begin
                ramp_mode <= cfg_ramp_en;
                step      <= cfg_ramp_step;
            end
            for (int k = 0; k < 5; k++) begin
                stg[k] <= stg_byp[k];
                if (cfg_commit) tgt[k] <= stg_byp[k];
                if (load_tgt) act[k] <= tgt[k];
                else if (load_ramp) act[k] <= ramp_val[k];
            end
        end
    end
endmodule

// File: tb/tb_iir_biquad_coef_ctrl.sv
// tb_iir_biquad_coef_ctrl: directed vector table plus hand sequences for the coefficient controller
module tb_iir_biquad_coef_ctrl;
    localparam int N = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_wr_en, cfg_commit, cfg_ramp_en, x0_valid, x0_ready, y0_valid;
    logic [2:0] cfg_wr_addr;
    logic [N-1:0] cfg_wr_data, cfg_ramp_step;
    logic [N-1:0] b0, b1, b2, a1, a2;
    logic busy, done;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    iir_biquad_coef_ctrl #(.N_BITS_P(N), .Q_BITS_P(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_commit(cfg_commit), .cfg_ramp_en(cfg_ramp_en), .cfg_ramp_step(cfg_ramp_step),
        .x0_valid(x0_valid), .x0_ready(x0_ready), .y0_valid(y0_valid),
        .cr_zero_b0(b0), .cr_zero_b1(b1), .cr_zero_b2(b2),
        .cr_pole_a1(a1), .cr_pole_a2(a2),
        .sts_busy(busy), .sts_done(done)
    );

    // hs: 0 = core busy (no edge), 1 = core idle and ready (safe edge), 2 = y0_valid (sample edge)
    typedef struct {
        bit wr; int addr; int data; bit commit; bit ramp; int step; int hs;
        int e0; int e1; int e2; int e3; int e4; bit eb; bit ed;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t mk(bit wr, int addr, int data, bit commit, bit ramp, int step, int hs,
                                int e0, int e1, int e2, int e3, int e4, bit eb, bit ed);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.commit = commit; v.ramp = ramp; v.step = step;
        v.hs = hs; v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.e4 = e4; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    task automatic drive(bit wr, int addr, int data, bit commit, bit ramp, int step, bit xv, bit xr, bit yv);
        cfg_wr_en = wr; cfg_wr_addr = 3'(addr); cfg_wr_data = data;
        cfg_commit = commit; cfg_ramp_en = ramp; cfg_ramp_step = step;
        x0_valid = xv; x0_ready = xr; y0_valid = yv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic signed [31:0] got, logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic check_out(string tag, int e0, int e1, int e2, int e3, int e4, bit eb, bit ed);
        chk({tag, " b0"}, b0, e0);
        chk({tag, " b1"}, b1, e1);
        chk({tag, " b2"}, b2, e2);
        chk({tag, " a1"}, a1, e3);
        chk({tag, " a2"}, a2, e4);
        chk({tag, " busy"}, {31'd0, busy}, {31'd0, eb});
        chk({tag, " done"}, {31'd0, done}, {31'd0, ed});
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_hold", 32768, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        check_out("after_reset", 32768, 0, 0, 0, 0, 0, 0);
        // jump with idle core: update two cycles after commit
        tv.push_back(mk(1, 0, 16384, 0, 0, 0,   1, 32768, 0, 0,     0, 0, 0, 0));
        tv.push_back(mk(1, 3, -1000, 0, 0, 0,   1, 32768, 0, 0,     0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0,     1, 0, 0,   1, 32768, 0, 0,     0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   1, 16384, 0, 0, -1000, 0, 0, 1));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   1, 16384, 0, 0, -1000, 0, 0, 0));
        // restore unity, a1 written in the commit cycle
        tv.push_back(mk(1, 0, 32768, 0, 0, 0,   1, 16384, 0, 0, -1000, 0, 0, 0));
        tv.push_back(mk(1, 3, 0,     1, 0, 0,   1, 16384, 0, 0, -1000, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   1, 32768, 0, 0,     0, 0, 0, 1));
        // ramp b0 32768 -> 32000 step 100
        tv.push_back(mk(1, 0, 32000, 0, 0, 0,   0, 32768, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0,     1, 1, 100, 0, 32768, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   0, 32768, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   1, 32668, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   1, 32668, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   2, 32568, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   0, 32568, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   2, 32468, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   2, 32368, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   2, 32268, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   2, 32168, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   2, 32068, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   2, 32000, 0, 0, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   2, 32000, 0, 0, 0, 0, 0, 0));
        // ramp down toward 31000, re-commit to 33000 mid-ramp
        tv.push_back(mk(1, 0, 31000, 0, 0, 0,   0, 32000, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0,     1, 1, 100, 0, 32000, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   2, 31900, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   2, 31800, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   2, 31700, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(1, 0, 33000, 1, 1, 300, 0, 31700, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   2, 32000, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   2, 32300, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   2, 32600, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   2, 32900, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   2, 33000, 0, 0, 0, 0, 0, 1));
        // ignored addresses, then write+commit b2 with step 0 (jump)
        tv.push_back(mk(1, 5, 888,   0, 0, 0,   1, 33000, 0, 0,   0, 0, 0, 0));
        tv.push_back(mk(1, 6, 777,   0, 0, 0,   1, 33000, 0, 0,   0, 0, 0, 0));
        tv.push_back(mk(1, 7, 999,   0, 0, 0,   1, 33000, 0, 0,   0, 0, 0, 0));
        tv.push_back(mk(1, 2, 500,   1, 1, 0,   1, 33000, 0, 0,   0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   1, 33000, 0, 500, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0,     0, 0, 0,   1, 33000, 0, 500, 0, 0, 0, 0));
        foreach (tv[i]) begin
            drive(tv[i].wr, tv[i].addr, tv[i].data, tv[i].commit, tv[i].ramp, tv[i].step,
                  1'b0, tv[i].hs == 1, tv[i].hs == 2);
            tick();
            check_out($sformatf("row%0d", i), tv[i].e0, tv[i].e1, tv[i].e2, tv[i].e3, tv[i].e4,
                      tv[i].eb, tv[i].ed);
        end
        // streaming core: x0_valid held, update lands only on the y0_valid cycle
        drive(1, 1, 1234, 1, 0, 0, 1, 0, 0);
        tick();
        check_out("stream_commit", 33000, 0, 500, 0, 0, 1, 0);
        for (int k = 0; k < 14; k++) begin
            drive(0, 0, 0, 0, 0, 0, 1, k % 7 == 0, k % 7 == 6);
            tick();
            check_out($sformatf("stream%0d", k), 33000, k >= 6 ? 1234 : 0, 500, 0, 0, k < 6, k == 6);
        end
        // reset in the middle of a ramp
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 1, 1000, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        check_out("preset_ramp1", 32000, 1234, 500, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        check_out("preset_ramp2", 31000, 1234, 500, 0, 0, 1, 0);
        rst_n = 1'b0;
        #2;
        check_out("async_reset", 32768, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, k % 2 == 0, k % 2 == 1);
            tick();
            check_out($sformatf("post_reset%0d", k), 32768, 0, 0, 0, 0, 0, 0);
        end
        drive(0, 0, 0, 1, 0, 0, 0, 1, 0);
        tick();
        check_out("reset_stage_commit", 32768, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        check_out("reset_stage_jump", 32768, 0, 0, 0, 0, 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
